// File: rtl/psum_out_fifo_if.sv
// psum_out_fifo_if
//   Bundles the psum collection buffer's data-path and handshake signals.
//   Parameters:
//     col     - number of array columns (one FIFO lane each)
//     psum_bw - width of one partial sum
//   Signals:
//     wr        per-lane write strobe (array valid bus)
//     in        packed lane data, lane i at [psum_bw*(i+1)-1 : psum_bw*i]
//     rd        row read request
//     out       registered row of psums, same packing as in
//     out_valid out was loaded by the previous edge's accepted read
//     o_valid   every lane holds at least one entry
//     o_full    at least one lane is full
//     o_ready   !o_full
//     overflow  sticky: a write to a full lane was dropped
//   Modports:
//     master - the producer/consumer side (array + SFP stage)
//     slave  - the buffer itself
//
//   Handshake: a lane write happens on a clock edge where wr[i]=1 and that
//   lane is not full before the edge; a row read happens on an edge where
//   rd=1 and o_valid=1 before the edge. Strobes presented outside those
//   conditions are ignored (a dropped write additionally sets overflow).
interface psum_out_fifo_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [col-1:0]         wr;
    logic [psum_bw*col-1:0] in;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   out_valid;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ready;
    logic                   overflow;

    modport master (
        output wr, in, rd,
        input  out, out_valid, o_valid, o_full, o_ready, overflow
    );

    modport slave (
        input  wr, in, rd,
        output out, out_valid, o_valid, o_full, o_ready, overflow
    );
endinterface

// File: rtl/psum_out_fifo.sv
// psum_out_fifo
//   Output-side collection buffer for the systolic MAC array. Each array
//   column writes its partial sum into its own circular FIFO lane whenever
//   its valid bit is set; because columns finish in a diagonal wavefront the
//   lanes fill at different times. A row becomes readable once every lane
//   holds at least one entry, and a single rd strobe pops one entry from
//   every lane into the registered out bus.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous active-high reset, clears pointers and outputs
//     bus   - psum_out_fifo_if.slave (wr/in/rd in, out/flags out)
//   Parameters:
//     col     - number of lanes
//     psum_bw - width of one psum
//     depth   - entries per lane, power of 2, >= 2
module psum_out_fifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input logic                  clk,
    input logic                  reset,
    psum_out_fifo_if.slave       bus
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = 1;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [aw:0]        wptr [col];
    logic [aw:0]        rptr [col];
    logic [psum_bw-1:0] mem  [col][depth];

    logic [col-1:0] lane_full;
    logic [col-1:0] lane_empty;
    logic           rd_accept;

    always_comb begin
        lane_full  = '0;
        lane_empty = '0;
        for (int i = 0; i < col; i++) begin
            lane_empty[i] = (wptr[i] == rptr[i]);
            lane_full[i]  = (wptr[i][aw-1:0] == rptr[i][aw-1:0]) &&
                            (wptr[i][aw] != rptr[i][aw]);
        end
    end

    // Status flags depend on pointers only, never on the current inputs.
    assign bus.o_valid = ~|lane_empty;
    assign bus.o_full  = |lane_full;
    assign bus.o_ready = ~bus.o_full;
    assign rd_accept   = bus.rd && bus.o_valid;

    // Storage is not reset; writes are suppressed on a reset edge so that
    // nothing from that cycle survives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                if (bus.wr[i] && !lane_full[i]) begin
                    mem[i][wptr[i][aw-1:0]] <= bus.in[i*psum_bw +: psum_bw];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                // Fullness is judged on pre-edge pointers, so a full lane
                // drops its write even when a row read is accepted this edge.
                if (bus.wr[i]) begin
                    if (lane_full[i]) begin
                        bus.overflow <= 1'b1;
                    end else begin
                        wptr[i] <= wptr[i] + ptr_one;
                    end
                end
                if (rd_accept) begin
                    bus.out[i*psum_bw +: psum_bw] <= mem[i][rptr[i][aw-1:0]];
                    rptr[i] <= rptr[i] + ptr_one;
                end
            end
            bus.out_valid <= rd_accept;
        end
    end
endmodule

// File: tb/tb_psum_out_fifo.sv
// tb_psum_out_fifo
//   Directed plus short random stimulus for psum_out_fifo (col=8,
//   psum_bw=16, depth=16). Per-lane queues predict lane occupancy and
//   dropped writes; each accepted row is pushed to exp_q when the read is
//   driven and popped when out_valid is observed.
module tb_psum_out_fifo;
    localparam int col     = 8;
    localparam int psum_bw = 16;
    localparam int depth   = 16;
    localparam int rw      = col * psum_bw;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    psum_out_fifo_if #(.col(col), .psum_bw(psum_bw)) bus ();

    psum_out_fifo #(.col(col), .psum_bw(psum_bw), .depth(depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [psum_bw-1:0] mq [col][$];
    logic [rw-1:0]      exp_q [$];
    logic [rw-1:0]      exp_out;
    logic               m_ovf;
    int                 checks;
    int                 failures;

    task automatic chk(input string tag, input logic [rw-1:0] obs, input logic [rw-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        logic all_ne;
        logic any_full;
        all_ne   = 1'b1;
        any_full = 1'b0;
        for (int i = 0; i < col; i++) begin
            if (mq[i].size() == 0) all_ne = 1'b0;
            if (mq[i].size() == depth) any_full = 1'b1;
        end
        chk("o_valid", rw'(bus.o_valid), rw'(all_ne));
        chk("o_full", rw'(bus.o_full), rw'(any_full));
        chk("o_ready", rw'(bus.o_ready), rw'(!any_full));
        chk("overflow", rw'(bus.overflow), rw'(m_ovf));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: present wr/in/rd, update the model with pre-edge judgments,
    // then check the post-edge outputs.
    task automatic cycle(input logic [col-1:0] w, input logic [rw-1:0] d, input logic r);
        logic           accept;
        logic [rw-1:0]  row;
        logic [col-1:0] pre_full;
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        accept = r;
        row    = '0;
        for (int i = 0; i < col; i++) begin
            if (mq[i].size() == 0) accept = 1'b0;
            pre_full[i] = (mq[i].size() == depth);
        end
        if (accept) begin
            for (int i = 0; i < col; i++) row[i*psum_bw +: psum_bw] = mq[i].pop_front();
            exp_q.push_back(row);
        end
        for (int i = 0; i < col; i++) begin
            if (w[i]) begin
                if (pre_full[i]) m_ovf = 1'b1;
                else mq[i].push_back(d[i*psum_bw +: psum_bw]);
            end
        end
        @(posedge clk);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
        chk("out_valid", rw'(bus.out_valid), rw'(accept));
        if (accept) begin
            exp_out = exp_q.pop_front();
            chk("out_row", bus.out, exp_out);
        end else begin
            chk("out_hold", bus.out, exp_out);
        end
        check_flags();
    endtask

    // Hold reset for n cycles with hostile wr/rd; none of it may take effect.
    task automatic do_reset(input int n);
        reset  = 1'b1;
        bus.wr = '1;
        bus.in = {col{16'hDEAD}};
        bus.rd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.wr = '0;
        bus.rd = 1'b0;
        for (int i = 0; i < col; i++) mq[i].delete();
        exp_q.delete();
        exp_out = '0;
        m_ovf   = 1'b0;
        chk("rst_out", bus.out, '0);
        chk("rst_out_valid", rw'(bus.out_valid), '0);
        check_flags();
    endtask

    function automatic logic [rw-1:0] lane_row(input int base, input int step);
        logic [rw-1:0] v;
        for (int i = 0; i < col; i++) v[i*psum_bw +: psum_bw] = psum_bw'(base + i * step);
        return v;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        checks   = 0;
        failures = 0;
        exp_out  = '0;
        m_ovf    = 1'b0;
        bus.wr   = '0;
        bus.in   = '0;
        bus.rd   = 1'b0;

        // Reset held 2 cycles with wr all-ones and rd high.
        do_reset(2);

        // Single row: lanes 1..8, read next cycle, then idle.
        cycle(8'hFF, lane_row(1, 1), 1'b0);
        cycle(8'h00, '0, 1'b1);
        cycle(8'h00, '0, 1'b0);

        // Diagonal wavefront: o_valid must stay low until lane 7 is written.
        for (int k = 0; k < col; k++) cycle(8'(1 << k), {col{16'(16'hA0 + k)}}, 1'b0);
        cycle(8'h00, '0, 1'b1);
        cycle(8'h00, '0, 1'b0);

        // Full / overflow on lane 0.
        for (int k = 0; k < depth; k++) cycle(8'h01, {col{16'(k)}}, 1'b0);
        cycle(8'h01, {col{16'd99}}, 1'b0);
        for (int k = 0; k < depth; k++) cycle(8'hFE, lane_row(16'h100 + k, 16'h10), 1'b0);
        for (int k = 0; k < depth; k++) cycle(8'h00, '0, 1'b1);
        cycle(8'h00, '0, 1'b1);  // read while empty is ignored

        do_reset(1);

        // Wrap-around streaming: prefill one row, then 40 cycles write+read.
        cycle(8'hFF, lane_row(0, 1), 1'b0);
        for (int n = 1; n <= 40; n++) cycle(8'hFF, lane_row(n * col, 1), 1'b1);
        cycle(8'h00, '0, 1'b1);

        do_reset(1);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            logic [rw-1:0] d;
            for (int i = 0; i < col; i++) d[i*psum_bw +: psum_bw] = 16'($urandom_range(0, 16'hFFFF));
            cycle(8'($urandom_range(0, 255)), d, 1'($urandom_range(0, 1)));
        end

        do_reset(1);

        // Reset mid-stream: 5 rows buffered, reset pulsed together with rd.
        for (int n = 0; n < 5; n++) cycle(8'hFF, lane_row(16'h500 + n * 16, 1), 1'b0);
        cycle(8'h00, '0, 1'b1);
        do_reset(1);
        cycle(8'hFF, lane_row(16'h7700, 3), 1'b0);
        cycle(8'h00, '0, 1'b1);
        cycle(8'h00, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_out_fifo.md
# psum_out_fifo

Output-side collection buffer for the systolic MAC array. Sits directly downstream of the array's bottom row: it captures each column's `out_s` partial sum on that column's `valid` bit. Columns complete in the staggered, diagonal wavefront order that the array produces. The block re-aligns them into full rows of `col` psums that the SFP/accumulation stage reads with a single strobe.

## Interface
- `col`, default 8: number of array columns, one FIFO lane per column.
- `psum_bw`, default 16: width of one partial sum.
- `depth`, default 16: entries per lane; must be a power of 2, ≥ 2.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset; one clock; all state cleared on the edge where sampled high.
- `wr`, input, `col`: per-lane write strobe; driven by the array `valid` bus.
- `in`, input, `psum_bw*col`: psum data; lane i uses bits [psum_bw*(i+1)-1 : psum_bw*i].
- `rd`, input, 1: row read request.
- `out`, output, `psum_bw*col`: registered row of psums; lane i in the same bit slice as `in`.
- `out_valid`, output, 1: `out` was updated by the previous edge's accepted read.
- `o_valid`, output, 1: every lane holds ≥ 1 entry; a row is readable.
- `o_full`, output, 1: at least one lane is full.
- `o_ready`, output, 1: equals `!o_full`.
- `overflow`, output, 1: sticky flag; a write was dropped.

## Operation
- Each lane is an independent circular FIFO with `depth` entries of `psum_bw` bits.
  - Write pointer and read pointer are each log2(depth)+1 bits wide.
  - Lane empty: pointers are equal.
  - Lane full: low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2·depth.
- Write, lane i: when `wr[i]`=1 and lane i is not full (pre-edge state), store the lane i slice of `in` at wptr[i], then increment wptr[i].
- Full lane: `wr[i]` to a full lane is dropped, sets `overflow`=1 and leaves that lane's pointers unchanged. Other lanes written in the same cycle proceed normally.
- Read accept: a read is accepted when `rd`=1 and `o_valid`=1 (pre-edge). On acceptance:
  - every lane's head entry is loaded into its `out` slice;
  - every rptr increments;
  - `out_valid`=1 for the following cycle.
- Read ignored: `rd` with `o_valid`=0 changes nothing, `out` holds, and `out_valid`=0.
- Simultaneous write + read on one lane: both take effect.
  - The count is unchanged.
  - Full and empty are judged on pre-edge state only, so a write to a lane that is full before the edge is dropped even if a read is accepted on that edge.
- No data transformation: bits are stored and returned verbatim, with no sign handling.
- Reset values:
  - all pointers 0;
  - `out`=0, `out_valid`=0, `overflow`=0;
  - hence `o_valid`=0, `o_full`=0, `o_ready`=1.
- Memory contents need not be cleared.
- Reset mid-operation: all buffered data is discarded, and no read or write on the reset edge takes effect.
- `overflow` clears only on reset.

## Timing
- Write latency: data written on edge N contributes to `o_valid` after edge N, so `o_valid` can rise in cycle N+1.
- Read latency: a read accepted on edge N gives `out` and `out_valid`=1 during cycle N+1. `out_valid` falls after edge N+1 unless another read is accepted on that edge.
- Throughput: one row per cycle, with back-to-back `rd` while `o_valid`=1.
- `o_valid`, `o_full`, `o_ready` are combinational from the pointers only; no input-to-output combinational path.
- `out` and `out_valid` are flops.

## Test plan
- Reset:
  - Stimulus: assert `reset` for 2 cycles with `wr`=all-ones and `rd`=1.
  - Required: `o_valid`=0, `o_ready`=1, `o_full`=0, `out`=0, `out_valid`=0, `overflow`=0 after release.
- Single row:
  - Stimulus: `wr`=8'hFF with lane i = i+1 (lane0=1 … lane7=8), then `rd` next cycle.
  - Required: one cycle later `out` lanes read 1..8, `out_valid`=1 for exactly 1 cycle, then `o_valid`=0.
- Diagonal wavefront:
  - Stimulus: `wr`=8'h01, 8'h02, … 8'h80 on consecutive cycles, with data 16'hA0+i.
  - Required: `o_valid` stays 0 until the cycle after lane 7's write; the following read returns 16'hA0..16'hA7.
- Full/overflow:
  - Stimulus: write lane 0 with values 0..15.
  - Required: `o_full`=1 and `o_ready`=0 after the 16th write.
  - Stimulus: 17th write (value 99).
  - Required: the write is dropped and `overflow`=1.
  - Stimulus: fill the other lanes, then 16 reads.
  - Required: lane 0 returns 0..15 in order, never 99.
- Wrap-around streaming:
  - Stimulus: prefill 1 row, then 40 cycles of simultaneous all-lane `wr` (incrementing data) and `rd`.
  - Required: `out` sequence is strictly in-order with no gaps, `o_valid` stays 1, `overflow`=0.
- Reset mid-stream:
  - Stimulus: 5 rows buffered, `reset` pulsed 1 cycle concurrently with `rd`.
  - Required: `out_valid`=0, `out`=0, `o_valid`=0 next cycle; a new row written afterwards reads back correctly.
